// File: rtl/ks_pkg.sv
// Shared definitions for the multi-word Kogge-Stone adder: FSM state encoding
// and helpers that size the chunk counter.
package ks_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  function automatic int nchunk_f(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk build still needs a one-bit counter.
  function automatic int cnt_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ks_prefix_adder.sv
// CHUNK-bit combinational Kogge-Stone adder with carry-in and carry-out.
// The carry-in is folded into bit 0's generate so the prefix tree yields true carries.
module ks_prefix_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  localparam int LEVELS = (CHUNK > 1) ? $clog2(CHUNK) : 0;

  logic [CHUNK-1:0] p_s;
  logic [CHUNK-1:0] g_s;
  logic [CHUNK-1:0] pv_s;
  logic [CHUNK-1:0] gn_s;
  logic [CHUNK-1:0] pn_s;

  // Prefix tree: each level combines (g,p) pairs at distance 2^level.
  always_comb begin
    p_s  = a ^ b;
    g_s  = (a & b) | CHUNK'(p_s[0] & ci);
    pv_s = p_s;
    gn_s = g_s;
    pn_s = pv_s;
    for (int l = 0; l < LEVELS; l++) begin
      gn_s = g_s;
      pn_s = pv_s;
      for (int i = 0; i < CHUNK; i++) begin
        if (i >= (1 << l)) begin
          gn_s[i] = g_s[i] | (pv_s[i] & g_s[i-(1<<l)]);
          pn_s[i] = pv_s[i] & pv_s[i-(1<<l)];
        end else begin
          gn_s[i] = g_s[i];
          pn_s[i] = pv_s[i];
        end
      end
      g_s  = gn_s;
      pv_s = pn_s;
    end
    s  = p_s ^ ((g_s << 1) | CHUNK'(ci));
    co = g_s[CHUNK-1];
  end

endmodule

// File: rtl/ks_multiword_adder.sv
// Sequential WIDTH-bit adder/subtractor processing CHUNK bits per cycle, LSB first.
// Define KSA_SUB_EN to enable subtraction via the sub input.
module ks_multiword_adder
  import ks_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
  localparam int CW     = cnt_w_f(NCHUNK);

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             co_r;
  logic             out_valid_r;
  logic             in_ready_r;

  logic [WIDTH-1:0] b_lat_s;
  logic             cin_lat_s;
  logic [CHUNK-1:0] chunk_sum_s;
  logic             chunk_co_s;
  logic [WIDTH-1:0] sum_nxt_s;
  logic [WIDTH-1:0] ins_s;

`ifdef KSA_SUB_EN
  // Subtraction as a + ~b + 1; co then reads as "no borrow".
  always_comb begin
    b_lat_s   = b ^ {WIDTH{sub}};
    cin_lat_s = sub ? 1'b1 : ci;
  end
`else
  logic unused_sub_s;
  assign unused_sub_s = sub;

  // Add-only build: operands pass straight through.
  always_comb begin
    b_lat_s   = b;
    cin_lat_s = ci;
  end
`endif

  ks_prefix_adder #(.CHUNK(CHUNK)) u_prefix (
    .a  (a_r[CHUNK-1:0]),
    .b  (b_r[CHUNK-1:0]),
    .ci (carry_r),
    .s  (chunk_sum_s),
    .co (chunk_co_s)
  );

  // New chunk results enter at the top of sum and shift down; after NCHUNK steps
  // chunk 0 has reached the bottom.
  always_comb begin
    ins_s                    = '0;
    ins_s[WIDTH-1 -: CHUNK]  = chunk_sum_s;
    sum_nxt_s                = (sum_r >> CHUNK) | ins_s;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      sum_r       <= '0;
      co_r        <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b_lat_s;
            carry_r    <= cin_lat_s;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_r     <= a_r >> CHUNK;
          b_r     <= b_r >> CHUNK;
          sum_r   <= sum_nxt_s;
          carry_r <= chunk_co_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == CW'(NCHUNK - 1)) begin
            co_r        <= chunk_co_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign co        = co_r;

endmodule

// File: tb/tb_ks_multiword_adder.sv
// Self-checking bench for ks_multiword_adder (WIDTH=32, CHUNK=8); directed vectors
// plus randomized operations checked against an arithmetic reference model.
module tb_ks_multiword_adder;

  localparam int W = 32;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ci = 1'b0;
  logic          sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          co;

  int checks = 0;
  int errors = 0;

  ks_multiword_adder #(.WIDTH(W), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .co(co)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic; in subtract mode co means a >= b.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mci, input logic msub);
`ifdef KSA_SUB_EN
    if (msub) return {(ma >= mb) ? 1'b1 : 1'b0, ma - mb};
`endif
    return {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mci};
  endfunction

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tci, input logic tsub, input logic [W-1:0] esum,
                        input logic eco, input int hold);
    int n;
    chk({tag, ":in_ready_idle"}, in_ready, 1);
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ci = 1'($urandom); sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ":latency"}, n, N);
    chk({tag, ":sum"}, sum, esum);
    chk({tag, ":co"}, co, eco);
    repeat (hold) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk({tag, ":hold_sum"}, sum, esum);
      chk({tag, ":hold_co"}, co, eco);
      chk({tag, ":hold_valid"}, out_valid, 1);
      chk({tag, ":hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ":idle_valid"}, out_valid, 0);
    chk({tag, ":idle_in_ready"}, in_ready, 1);
    chk({tag, ":idle_sum_kept"}, sum, esum);
  endtask

  initial begin
    logic [W:0]   r;
    logic [W-1:0] ra, rb;
    logic         rci, rsub;

    #12;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_co", co, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 0);
    run_op("mixed", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 0);
`ifdef KSA_SUB_EN
    run_op("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 0);
    run_op("sub_pos", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 0);
`else
    run_op("sub_ignored", 32'd5, 32'd7, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 0);
`endif
    run_op("hold10", 32'h8000_0000, 32'h8000_0001, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 10);

    // Reset mid-operation discards it.
    in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1111_1111; ci = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_run_out_valid", out_valid, 0);
    chk("rst_run_sum", sum, 0);
    chk("rst_run_co", co, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_run_in_ready", in_ready, 1);
    chk("rst_run_out_valid_after", out_valid, 0);
    run_op("after_rst", 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      ra = $urandom; rb = $urandom; rci = 1'($urandom); rsub = 1'($urandom);
      if (i % 5 == 0) rb = ~ra;
      r = model(ra, rb, rci, rsub);
      run_op($sformatf("rand%0d", i), ra, rb, rci, rsub, r[W-1:0], r[W], int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ks_multiword_adder.md
KS_MULTIWORD_ADDER -- requirements
Module: ks_multiword_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, meaning bits added per cycle by the prefix adder; WIDTH SHALL be a multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have ports as follows; one clock; reset is asynchronous and active-low.
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in (add mode)
- sub  input  1  1 = compute a - b
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- co  output  1  carry-out; in sub mode 1 = no borrow

Function
REQ-004 SHALL implement FSM states IDLE, RUN and DONE.
REQ-005 In IDLE, in_ready SHALL be 1; in_valid=1 SHALL be accepted at the clock edge, SHALL latch a, b XOR {WIDTH{sub}}, and carry = sub ? 1 : ci, and SHALL move to RUN with chunk counter 0.
REQ-006 In RUN, each cycle SHALL add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK, LSB first) with the carry register through a CHUNK-bit Kogge-Stone prefix adder.
REQ-007 In RUN, each cycle SHALL write the chunk result into sum and store the chunk carry-out in the carry register.
REQ-008 After chunk NCHUNK-1, the FSM SHALL enter DONE with co = final carry.
REQ-009 out_valid SHALL rise exactly NCHUNK cycles after the accepting edge; NCHUNK=1 SHALL give 1-cycle latency.
REQ-010 In DONE, out_valid SHALL be 1 and sum/co SHALL hold stable until out_ready=1; the FSM SHALL then return to IDLE on that edge.
REQ-011 in_ready SHALL be 0 in RUN and DONE; only one operation SHALL be outstanding; in_valid outside IDLE SHALL be ignored.
REQ-012 Operands SHALL be sampled only at acceptance; input changes during RUN SHALL NOT affect the result.
REQ-013 Carry out of the MSB chunk SHALL go only to co; sum SHALL wrap modulo 2^WIDTH.
REQ-014 In IDLE, sum/co SHALL keep the last result; out_valid SHALL be 0.

Reset
REQ-015 rst_n=0 SHALL asynchronously force IDLE, in_ready=1 (after reset), out_valid=0, sum=0, co=0, carry=0, counter=0.
REQ-016 Reset during RUN or DONE SHALL discard the operation with no partial result visible.

Configuration
REQ-017 Macro KSA_SUB_EN defined: sub SHALL select subtraction per REQ-005.
REQ-018 Macro KSA_SUB_EN undefined: the sub port SHALL remain present but be ignored (treated as 0), and no inversion logic SHALL be built.

Structure
REQ-019 Package ks_pkg SHALL hold the FSM state encoding and the NCHUNK/counter-width helper constants.
REQ-020 Sub-module ks_prefix_adder (parametrised CHUNK-bit combinational Kogge-Stone with ci/co, log2(CHUNK) prefix levels) SHALL be instantiated once; all sequencing SHALL live in ks_multiword_adder.

Verification (WIDTH=32, CHUNK=8)
REQ-021 a=0xFFFFFFFF, b=0x00000001, ci=0 -> sum=0x00000000, co=1, out_valid exactly 4 cycles after accept.
REQ-022 a=0x12345678, b=0x9ABCDEF0, ci=1 -> sum=0xACF13569, co=0.
REQ-023 KSA_SUB_EN defined, sub=1, a=5, b=7 -> sum=0xFFFFFFFE, co=0; a=7, b=5 -> sum=0x00000002, co=1.
REQ-024 Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 -> sum/co stable, in_ready=0, no second accept; out_ready=1 -> IDLE next cycle.
REQ-025 Assert rst_n=0 after 2 RUN cycles -> out_valid=0, sum=0, in_ready=1 after release; next op 1+1 gives 2, co=0.
REQ-026 KSA_SUB_EN undefined, sub=1, a=5, b=7, ci=0 -> sum=0x0000000C, co=0.
